// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter (fetch = port 0, data = port 1) onto a single
// request/ready memory channel, with a WAIT watchdog and read/miss statistics.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_miss,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              pick;

  logic              ack0_d, ack1_d, err_d, busy_d;
  logic              mem_req_d, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, rdata_d;
  logic [CNT_W-1:0]  rd_cnt_d, miss_cnt_d;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    wdog_d      = wdog_q;
    pick        = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err_d       = err;
    mem_req_d   = mem_req;
    mem_wr_d    = mem_wr;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rdata_d     = rdata;
    rd_cnt_d    = rd_cnt;
    miss_cnt_d  = miss_cnt;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes first.
          pick        = (req0 && req1) ? ~last_gnt_q : req1;
          gnt_d       = pick;
          last_gnt_d  = pick;
          mem_wr_d    = pick ? wr1 : wr0;
          mem_addr_d  = pick ? addr1 : addr0;
          mem_wdata_d = pick ? wdata1 : wdata0;
          mem_req_d   = 1'b1;
          wdog_d      = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_wr ? '0 : mem_rdata;
          err_d     = 1'b0;
          ack0_d    = ~gnt_q;
          ack1_d    = gnt_q;
          state_d   = RESP;
          if (!mem_wr) begin
            if (rd_cnt != CNT_MAX) rd_cnt_d = rd_cnt + CNT_W'(1);
            if (mem_miss && miss_cnt != CNT_MAX) miss_cnt_d = miss_cnt + CNT_W'(1);
          end
        end else if (wdog_q == WD_LAST) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          ack0_d    = ~gnt_q;
          ack1_d    = gnt_q;
          state_d   = RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: every register, outputs included, is cleared by the asynchronous
  // reset so a mid-transaction reset drops mem_req without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      wdog_q     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      rd_cnt     <= '0;
      miss_cnt   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wdog_q     <= wdog_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      err        <= err_d;
      busy       <= busy_d;
      mem_req    <= mem_req_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rdata      <= rdata_d;
      rd_cnt     <= rd_cnt_d;
      miss_cnt   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-timeline model predicts
// every output each cycle; directed cases pin the model with literal values.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy, mem_req, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rdata, mem_wdata;
  logic          mem_ready = 0, mem_miss = 0;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   rd_cnt, miss_cnt;

  logic          s_ack0, s_ack1, s_err, s_busy, s_mem_req, s_mem_wr;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_rdata, s_mem_wdata;
  logic [1:0]    s_rd_cnt, s_miss_cnt;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_miss(mem_miss),
    .rd_cnt(rd_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-counter twin on the same stimulus, used for saturation.
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .err(s_err), .busy(s_busy),
    .mem_req(s_mem_req), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_miss(mem_miss),
    .rd_cnt(s_rd_cnt), .miss_cnt(s_miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: one in-flight transaction described by its grant edge and the edge
  // on which it completes; outputs follow from where "now" sits on that line.
  int            en;
  bit            m_active, m_port, m_wr, m_to, m_mmiss, last_gnt;
  int            m_g, m_done, m_lat;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_mrdata;

  bit            e_mem_req, e_ack0, e_ack1, e_err, e_busy, e_mem_wr;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_rdata;
  int            e_rd, e_miss, e_rd_s, e_miss_s;

  int            mode;          // 0 directed, 1 random, 2 both ports always requesting
  int            forced_lat;
  logic [DW-1:0] forced_rdata;
  bit            forced_miss;
  bit            dir_valid[2];
  bit            dir_wr[2];
  logic [AW-1:0] dir_addr[2];
  logic [DW-1:0] dir_wdata[2];
  int            gnt_log[$];
  int            mreq_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; last_gnt = 1; en = 0;
    e_mem_req = 0; e_ack0 = 0; e_ack1 = 0; e_err = 0; e_busy = 0; e_mem_wr = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_rdata = '0;
    e_rd = 0; e_miss = 0; e_rd_s = 0; e_miss_s = 0;
  endfunction

  task automatic post(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dir_valid[p] = 1; dir_wr[p] = w; dir_addr[p] = a; dir_wdata[p] = d;
  endtask

  task automatic compare_all();
    check("mem_req", mem_req, e_mem_req);
    check("ack0", ack0, e_ack0);
    check("ack1", ack1, e_ack1);
    check("err", err, e_err);
    check("busy", busy, e_busy);
    check("mem_wr", mem_wr, e_mem_wr);
    check("mem_addr", mem_addr, e_mem_addr);
    check("mem_wdata", mem_wdata, e_mem_wdata);
    check("rdata", rdata, e_rdata);
    check("rd_cnt", rd_cnt, e_rd);
    check("miss_cnt", miss_cnt, e_miss);
    check("rd_cnt_sat", s_rd_cnt, e_rd_s);
    check("miss_cnt_sat", s_miss_cnt, e_miss_s);
  endtask

  task automatic drive_req();
    if (e_ack0) req0 = 0;
    else if (!req0 && dir_valid[0]) begin
      req0 = 1; wr0 = dir_wr[0]; addr0 = dir_addr[0]; wdata0 = dir_wdata[0]; dir_valid[0] = 0;
    end else if (!req0 && ((mode == 1 && $urandom_range(2) == 0) || mode == 2)) begin
      req0 = 1; wr0 = (mode == 1) ? 1'($urandom_range(1)) : 1'b0; addr0 = $urandom; wdata0 = $urandom;
    end
    if (e_ack1) req1 = 0;
    else if (!req1 && dir_valid[1]) begin
      req1 = 1; wr1 = dir_wr[1]; addr1 = dir_addr[1]; wdata1 = dir_wdata[1]; dir_valid[1] = 0;
    end else if (!req1 && ((mode == 1 && $urandom_range(2) == 0) || mode == 2)) begin
      req1 = 1; wr1 = (mode == 1) ? 1'($urandom_range(1)) : 1'b0; addr1 = $urandom; wdata1 = $urandom;
    end
  endtask

  task automatic drive_mem();
    if (m_active && !m_to && (en + 1) == m_g + 1 + m_lat) begin
      mem_ready = 1; mem_rdata = m_mrdata; mem_miss = m_mmiss;
    end else begin
      mem_ready = 0; mem_rdata = $urandom; mem_miss = 1'($urandom_range(1));
    end
  endtask

  function automatic int pick_lat();
    int r = $urandom_range(9);
    if (r < 6) return $urandom_range(3);
    if (r == 6) return T - 2;
    if (r == 7) return T - 1;
    if (r == 8) return 1000;
    return $urandom_range(5);
  endfunction

  task automatic model_edge();
    en++;
    if (m_active && en == m_done) begin
      e_mem_req = 0;
      e_ack0 = !m_port; e_ack1 = m_port;
      e_err = m_to;
      e_rdata = (m_to || m_wr) ? '0 : m_mrdata;
      if (!m_to && !m_wr) begin
        if (e_rd < 65535) e_rd++;
        if (e_rd_s < 3) e_rd_s++;
        if (m_mmiss && e_miss < 65535) e_miss++;
        if (m_mmiss && e_miss_s < 3) e_miss_s++;
      end
    end else if (m_active && en == m_done + 1) begin
      e_ack0 = 0; e_ack1 = 0; e_err = 0; e_busy = 0; m_active = 0;
    end else if (!m_active && (req0 || req1)) begin
      m_port  = (req0 && req1) ? !last_gnt : req1;
      last_gnt = m_port;
      m_wr    = m_port ? wr1 : wr0;
      m_addr  = m_port ? addr1 : addr0;
      m_wdata = m_port ? wdata1 : wdata0;
      m_lat   = (mode == 1) ? pick_lat() : forced_lat;
      m_mrdata = (mode == 1) ? DW'($urandom) : forced_rdata;
      m_mmiss  = (mode == 1) ? 1'($urandom_range(1)) : forced_miss;
      m_to    = (m_lat > T - 1);
      m_g     = en;
      m_done  = en + 1 + (m_to ? T - 1 : m_lat);
      m_active = 1;
      e_mem_req = 1; e_busy = 1;
      e_mem_wr = m_wr; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
      gnt_log.push_back(int'(m_port));
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (mem_req) mreq_cycles++;
    compare_all();
    drive_req();
    drive_mem();
    model_edge();
  endtask

  // Returns at the negedge of the ack cycle, so DUT outputs can be read directly.
  task automatic wait_ack(input string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = e_ack0 || e_ack1;
    end
    check({name, "_bound"}, seen, 1'b1);
    if (seen) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (req0 || req1 || m_active || dir_valid[0] || dir_valid[1]); i++)
      step();
    check("drain_bound", req0 || req1 || m_active, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req0 = 0; req1 = 0; mem_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    mode = 0; forced_lat = 0; forced_rdata = '0; forced_miss = 0;
    dir_valid[0] = 0; dir_valid[1] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rd_cnt", rd_cnt, 16'h0);
    rst_n = 1;

    // Single read with two wait states and a miss.
    forced_lat = 2; forced_rdata = 32'hDEADBEEF; forced_miss = 1;
    post(0, 1'b0, 32'h100, 32'h0);
    wait_ack("read_ack");
    check("read_ack0", ack0, 1'b1);
    check("read_rdata", rdata, 32'hDEADBEEF);
    check("read_err", err, 1'b0);
    check("read_rd_cnt", rd_cnt, 16'd1);
    check("read_miss_cnt", miss_cnt, 16'd1);

    // Write on port 1.
    forced_lat = 1; forced_rdata = 32'hCAFEF00D; forced_miss = 1;
    post(1, 1'b1, 32'h20, 32'h55AA);
    wait_ack("write_ack");
    check("write_ack1", ack1, 1'b1);
    check("write_rdata", rdata, 32'h0);
    check("write_mem_wr", mem_wr, 1'b1);
    check("write_mem_addr", mem_addr, 32'h20);
    check("write_mem_wdata", mem_wdata, 32'h55AA);
    check("write_rd_cnt", rd_cnt, 16'd1);

    // Watchdog abort: memory never answers.
    forced_lat = 1000;
    post(0, 1'b0, 32'h300, 32'h0);
    mreq_cycles = 0;
    wait_ack("timeout_ack");
    check("timeout_ack0", ack0, 1'b1);
    check("timeout_err", err, 1'b1);
    check("timeout_rdata", rdata, 32'h0);
    check("timeout_mem_req", mem_req, 1'b0);
    check("timeout_wait_cycles", mreq_cycles, T);
    check("timeout_rd_cnt", rd_cnt, 16'd1);

    // Ready arrives in the expiry cycle: ready wins.
    forced_lat = T - 1; forced_rdata = 32'h12345678; forced_miss = 0;
    post(0, 1'b0, 32'h400, 32'h0);
    mreq_cycles = 0;
    wait_ack("race_ack");
    check("race_err", err, 1'b0);
    check("race_rdata", rdata, 32'h12345678);
    check("race_wait_cycles", mreq_cycles, T);
    check("race_rd_cnt", rd_cnt, 16'd2);
    step();

    // Reset in WAIT of a port-0 transaction: mem_req drops with no edge.
    forced_lat = 1000;
    post(0, 1'b0, 32'h500, 32'h0);
    repeat (4) step();
    @(negedge clk);
    rst_n = 0; req0 = 0; req1 = 0; mem_ready = 0;
    #1;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mid_no_ack", ack0 | ack1, 1'b0);
    rst_n = 1;

    // Continuous tie: port 0 first (last_gnt reset to 1), then alternate.
    mode = 2; forced_lat = 0; forced_rdata = 32'hA5A5A5A5; forced_miss = 0;
    gnt_log.delete();
    for (int i = 0; i < 200 && gnt_log.size() < 6; i++) step();
    check("tie_grants", gnt_log.size() >= 4, 1'b1);
    if (gnt_log.size() >= 4) begin
      check("tie_gnt0", gnt_log[0], 0);
      check("tie_gnt1", gnt_log[1], 1);
      check("tie_gnt2", gnt_log[2], 0);
      check("tie_gnt3", gnt_log[3], 1);
    end
    mode = 0;
    drain();

    // Saturation of the 2-bit counters after five missed reads.
    do_reset();
    forced_lat = 0; forced_rdata = 32'h0BADF00D; forced_miss = 1;
    for (int i = 0; i < 5; i++) begin
      post(1, 1'b0, AW'(i), 32'h0);
      wait_ack("sat_ack");
    end
    check("sat_rd_cnt", s_rd_cnt, 2'd3);
    check("sat_miss_cnt", s_miss_cnt, 2'd3);
    check("wide_rd_cnt", rd_cnt, 16'd5);
    check("wide_miss_cnt", miss_cnt, 16'd5);

    // Randomised traffic against the model.
    mode = 1;
    repeat (3000) step();
    mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter between the core's instruction-fetch port (port 0) and data port (port 1) and the single cache/RAM memory path. It serialises read/write requests onto one downstream request/ready channel and holds each transaction until the memory side completes it. It returns read data with a per-port one-cycle acknowledge, aborts stalled transactions with a watchdog, and counts completed reads and read misses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles in WAIT before abort (>=2)
- CNT_W, 16, statistics counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  port request; held high, with fields stable, until the matching ack
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  request address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse for that port
- rdata  out  DATA_W  read data; valid while an ack is high
- err  out  1  timeout abort; valid while an ack is high
- busy  out  1  high in every state except IDLE
- mem_req  out  1  downstream request, level
- mem_wr, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  latched request fields
- mem_ready  in  1  downstream completion
- mem_rdata  in  DATA_W  downstream read data; valid with mem_ready
- mem_miss  in  1  read was a cache miss; valid with mem_ready
- rd_cnt, miss_cnt  out  CNT_W  completed reads and missed reads

## Operation
- FSM states are IDLE, WAIT and RESP. All outputs are registered.
- IDLE, with any req high:
  - Grant one port.
  - Latch that port's wr/addr/wdata into mem_wr/mem_addr/mem_wdata.
  - Set mem_req=1, clear the watchdog counter, go to WAIT.
- IDLE with no req: stay in IDLE, mem_req=0.
- Arbitration:
  - One request high: that port wins.
  - Both high: the port that is not last_gnt wins.
  - last_gnt updates on each grant; its reset value is 1, so port 0 wins the first tie.
- WAIT, mem_ready=1:
  - mem_req=0.
  - rdata = mem_rdata for reads; rdata = 0 for writes.
  - err=0, raise the granted port's ack, go to RESP.
  - Completed read: rd_cnt+1; also miss_cnt+1 if mem_miss=1.
- WAIT, mem_ready=0: watchdog counter+1. When the counter reaches TIMEOUT-1:
  - mem_req=0, rdata=0, err=1.
  - Raise the granted port's ack, go to RESP.
  - No counter update.
- mem_ready=1 in the same cycle the watchdog expires: ready wins, err=0.
- RESP: ack, rdata and err are driven for this single cycle. Then ack=0, err=0, go to IDLE. rdata holds its value.
- Requesters must deassert req in the cycle ack is seen. A req still high when IDLE is re-entered starts a new transaction.
- Counters saturate at 2^CNT_W-1 and do not wrap. miss_cnt <= rd_cnt always.
- req changes on the non-granted port during WAIT/RESP are ignored until IDLE. Changes to the granted port's fields after the grant do not affect mem_* outputs.

## Timing
- Reset values (asynchronous, immediate): state IDLE, last_gnt=1, watchdog=0.
  - Zero: mem_req, mem_wr, mem_addr, mem_wdata, ack0, ack1, err, rdata, busy, rd_cnt, miss_cnt.
- Reset asserted mid-transaction:
  - mem_req drops with no clock edge.
  - The transaction is abandoned with no ack.
- Edge E0 samples req in IDLE; mem_req is high after E0.
- mem_ready sampled high at edge E1; ack is high for the cycle after E1.
- The RESP exit edge returns to IDLE. The next grant is sampled at the following edge.
- Zero-wait-state memory: 3 edges per transaction, back-to-back.
- Worst case: ack after TIMEOUT WAIT cycles, with err=1.
- mem_req stays continuously high through WAIT. The downstream may assert mem_ready only while mem_req=1.

## Test plan
- Single read:
  - Stimulus: req0=1, addr0=0x100; memory replies mem_ready after 2 cycles with mem_rdata=0xDEADBEEF, mem_miss=1.
  - Response: ack0 for one cycle with rdata=0xDEADBEEF, err=0; rd_cnt=1, miss_cnt=1.
- Simultaneous requests:
  - Stimulus: after reset, req0 and req1 high together and re-requested continuously.
  - Response: grants alternate 0,1,0,1; each ack is exactly one cycle; no port is starved.
- Write:
  - Stimulus: req1=1, wr1=1, addr1=0x20, wdata1=0x55AA.
  - Response: mem_wr=1, mem_addr=0x20, mem_wdata=0x55AA; ack1 with rdata=0; rd_cnt unchanged.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_ready never asserted.
  - Response: ack0 with err=1, rdata=0 after 8 WAIT cycles; mem_req=0 after the abort.
- Timeout race:
  - Stimulus: mem_ready first asserted in the expiry cycle.
  - Response: err=0 and data returned.
- Reset and saturation:
  - Stimulus 1: rst_n pulled low during WAIT.
  - Response 1: mem_req=0 immediately, no ack, last_gnt=1.
  - Stimulus 2: CNT_W=2, 5 missed reads.
  - Response 2: rd_cnt=3, miss_cnt=3.
